// File: rtl/ex_mem_stage.sv
// EX/MEM boundary register: 2-entry skid buffer carrying the ALU result and memory/write-back
// control. It also resolves BEQ-type branches from the zero flag and drives a forwarding tap.
module ex_mem_stage #(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] result_i,
    input  logic              zero_i,
    input  logic [DATA_W-1:0] store_data_i,
    input  logic [DATA_W-1:0] pc_branch_i,
    input  logic [REG_W-1:0]  wb_reg_i,
    input  logic              regwrite_i,
    input  logic              memread_i,
    input  logic              memwrite_i,
    input  logic              branch_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic [DATA_W-1:0] store_data_o,
    output logic [REG_W-1:0]  wb_reg_o,
    output logic              regwrite_o,
    output logic              memread_o,
    output logic              memwrite_o,
    output logic              branch_taken_o,
    output logic [DATA_W-1:0] branch_target_o,
    output logic              fwd_valid_o,
    output logic [REG_W-1:0]  fwd_reg_o,
    output logic [DATA_W-1:0] fwd_data_o
);

    localparam int PW = 2 * DATA_W + REG_W + 3;

    logic          m_valid, s_valid;
    logic [PW-1:0] m_pl, s_pl, in_pl;
    logic          accept, pop;

    assign in_pl  = {result_i, store_data_i, wb_reg_i, regwrite_i, memread_i, memwrite_i};
    assign accept = valid_i & ready_o;
    assign pop    = m_valid & ready_i;

    // ready_o is a flop, so ready_i never reaches the EX side combinationally.
    assign ready_o = ~s_valid;
    assign valid_o = m_valid;
    assign {result_o, store_data_o, wb_reg_o, regwrite_o, memread_o, memwrite_o} = m_pl;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            m_pl    <= '0;
            s_pl    <= '0;
        end else if (flush_i) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else if (!m_valid || pop) begin
            if (s_valid) begin
                // S full implies ready_o=0, so no beat can be accepted this cycle.
                m_pl    <= s_pl;
                m_valid <= 1'b1;
                s_valid <= 1'b0;
            end else if (accept) begin
                m_pl    <= in_pl;
                m_valid <= 1'b1;
            end else begin
                m_valid <= 1'b0;
            end
        end else if (accept) begin
            s_pl    <= in_pl;
            s_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            branch_taken_o  <= 1'b0;
            branch_target_o <= '0;
        end else begin
            branch_taken_o <= accept & branch_i & zero_i & ~flush_i;
            if (accept && branch_i && zero_i && !flush_i)
                branch_target_o <= pc_branch_i;
        end
    end

    assign fwd_valid_o = m_valid & regwrite_o & (wb_reg_o != '0);
    assign fwd_reg_o   = wb_reg_o;
    assign fwd_data_o  = result_o;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Scoreboard bench for ex_mem_stage: stimulus pushes accepted beats into a FIFO model,
// a negedge monitor compares occupancy, head payload, forwarding and branch outputs.
module tb_ex_mem_stage;

    typedef struct packed {
        logic [31:0] result;
        logic [31:0] store;
        logic [4:0]  wb;
        logic        rw;
        logic        mr;
        logic        mw;
    } beat_t;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        flush_i = 1'b0, valid_i = 1'b0, ready_i = 1'b0;
    logic [31:0] result_i = '0, store_data_i = '0, pc_branch_i = '0;
    logic [4:0]  wb_reg_i = '0;
    logic        zero_i = 1'b0, regwrite_i = 1'b0, memread_i = 1'b0, memwrite_i = 1'b0, branch_i = 1'b0;
    logic        ready_o, valid_o, regwrite_o, memread_o, memwrite_o, branch_taken_o, fwd_valid_o;
    logic [31:0] result_o, store_data_o, branch_target_o, fwd_data_o;
    logic [4:0]  wb_reg_o, fwd_reg_o;

    ex_mem_stage #(.DATA_W(32), .REG_W(5)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
        .result_i(result_i), .zero_i(zero_i), .store_data_i(store_data_i), .pc_branch_i(pc_branch_i),
        .wb_reg_i(wb_reg_i), .regwrite_i(regwrite_i), .memread_i(memread_i), .memwrite_i(memwrite_i),
        .branch_i(branch_i), .valid_o(valid_o), .ready_i(ready_i), .result_o(result_o),
        .store_data_o(store_data_o), .wb_reg_o(wb_reg_o), .regwrite_o(regwrite_o),
        .memread_o(memread_o), .memwrite_o(memwrite_o), .branch_taken_o(branch_taken_o),
        .branch_target_o(branch_target_o), .fwd_valid_o(fwd_valid_o), .fwd_reg_o(fwd_reg_o),
        .fwd_data_o(fwd_data_o)
    );

    always #5 clk = ~clk;

    int    errors = 0, checks = 0;
    beat_t q[$];
    bit    pending = 0;
    bit    mon_en = 0;
    bit    br_next = 0, br_now = 0;
    logic [31:0] tgt_next = '0, tgt_now = '0;

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic beat_t rand_beat();
        beat_t b;
        b.result = $urandom;
        b.store  = $urandom;
        b.wb     = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
        b.rw     = 1'($urandom);
        b.mr     = 1'($urandom);
        b.mw     = 1'($urandom);
        return b;
    endfunction

    function automatic beat_t mk(input logic [31:0] r, input logic [4:0] w, input logic rw);
        beat_t b;
        b = rand_beat();
        b.result = r;
        b.wb = w;
        b.rw = rw;
        return b;
    endfunction

    // One cycle of stimulus, driven 1 time unit after the rising edge.
    task automatic cycle(input bit v, input beat_t b, input bit br, input bit z,
                         input logic [31:0] pc, input bit rdy, input bit fl, output bit acc);
        @(posedge clk);
        #1;
        br_now  = br_next;
        tgt_now = tgt_next;
        valid_i = v; flush_i = fl; ready_i = rdy;
        {result_i, store_data_i, wb_reg_i, regwrite_i, memread_i, memwrite_i} = b;
        branch_i = br; zero_i = z; pc_branch_i = pc;
        acc = v && ready_o;
        pending = acc && !fl;
        if (pending) q.push_back(b);
        br_next = acc && br && z && !fl;
        if (br_next) tgt_next = pc;
    endtask

    task automatic idle(input bit rdy);
        bit a;
        cycle(0, rand_beat(), 0, 0, '0, rdy, 0, a);
    endtask

    // Offer a beat until accepted, bounded.
    task automatic send(input beat_t b, input bit br, input bit z, input logic [31:0] pc, input bit rdy);
        bit a;
        a = 0;
        for (int t = 0; t < 20 && !a; t++) cycle(1, b, br, z, pc, rdy, 0, a);
        if (!a) begin
            errors++; checks++;
            $display("FAIL send_timeout: beat %0h not accepted", b.result);
        end
    endtask

    always @(negedge clk) begin : monitor
        int    in_dut;
        beat_t h;
        if (mon_en) begin
            in_dut = q.size() - (pending ? 1 : 0);
            check("ready_o", 128'(ready_o), 128'(in_dut < 2));
            check("valid_o", 128'(valid_o), 128'(in_dut > 0));
            if (valid_o) begin
                if (q.size() == 0) begin
                    errors++; checks++;
                    $display("FAIL unexpected_beat: result_o %0h with empty scoreboard", result_o);
                end else begin
                    h = q[0];
                    check("payload", 128'({result_o, store_data_o, wb_reg_o, regwrite_o, memread_o, memwrite_o}), 128'(h));
                    check("fwd_valid", 128'(fwd_valid_o), 128'(h.rw && h.wb != 0));
                    check("fwd_reg_data", 128'({fwd_reg_o, fwd_data_o}), 128'({h.wb, h.result}));
                    if (ready_i) void'(q.pop_front());
                end
            end
            if (flush_i) q.delete();
            check("branch_taken", 128'(branch_taken_o), 128'(br_now));
            check("branch_target", 128'(branch_target_o), 128'(tgt_now));
        end
    end

    initial begin
        bit a;
        #1;
        check("rst_valid", 128'(valid_o), 128'(0));
        check("rst_ready", 128'(ready_o), 128'(1));
        check("rst_outs", 128'({result_o, branch_taken_o, branch_target_o, fwd_valid_o}), 128'(0));
        #11 rst_i = 1'b1;
        mon_en = 1;

        // Back-to-back beats with ready_i=1.
        for (int i = 1; i <= 4; i++) send(mk(32'(i), 5'd3, 1), 0, 0, '0, 1);
        idle(1); idle(1);

        // Back-pressure: two beats stored, third held until MEM accepts.
        cycle(1, mk(32'h11, 5'd1, 1), 0, 0, '0, 0, 0, a);
        cycle(1, mk(32'h12, 5'd2, 1), 0, 0, '0, 0, 0, a);
        cycle(1, mk(32'h13, 5'd3, 1), 0, 0, '0, 0, 0, a);
        check("held_beat_not_accepted", 128'(a), 128'(0));
        send(mk(32'h13, 5'd3, 1), 0, 0, '0, 1);
        idle(1); idle(1); idle(1);

        // Branch taken, then not taken.
        send(mk(32'h5, 5'd0, 0), 1, 1, 32'h0040_0020, 1);
        idle(1); idle(1);
        send(mk(32'h6, 5'd0, 0), 1, 0, 32'h0badf00d, 1);
        idle(1); idle(1);

        // Flush with both entries full and a beat offered.
        cycle(1, mk(32'h21, 5'd4, 1), 0, 0, '0, 0, 0, a);
        cycle(1, mk(32'h22, 5'd5, 1), 0, 0, '0, 0, 0, a);
        cycle(1, mk(32'h23, 5'd6, 1), 1, 1, 32'h1234, 0, 1, a);
        idle(1); idle(1);

        // Forwarding to r0 and to r8.
        send(mk(32'h77, 5'd0, 1), 0, 0, '0, 1);
        send(mk(32'hDEAD_BEEF, 5'd8, 1), 0, 0, '0, 1);
        idle(0); idle(1); idle(1);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++)
            cycle($urandom_range(0, 9) < 7, rand_beat(), 1'($urandom), 1'($urandom), $urandom,
                  $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0, a);
        for (int i = 0; i < 4; i++) idle(1);

        // Asynchronous reset with both entries full.
        cycle(1, mk(32'h31, 5'd7, 1), 1, 1, 32'h4444, 0, 0, a);
        cycle(1, mk(32'h32, 5'd9, 1), 0, 0, '0, 0, 0, a);
        @(posedge clk);
        #2;
        mon_en = 0;
        rst_i = 1'b0;
        #1;
        check("arst_valid", 128'(valid_o), 128'(0));
        check("arst_ready", 128'(ready_o), 128'(1));
        check("arst_outs", 128'({result_o, store_data_o, branch_taken_o, branch_target_o, fwd_valid_o}), 128'(0));
        valid_i = 0;
        q.delete();
        pending = 0; br_next = 0; tgt_next = '0; br_now = 0; tgt_now = '0;
        #4 rst_i = 1'b1;
        mon_en = 1;
        check("post_rst_ready", 128'(ready_o), 128'(1));
        send(mk(32'h41, 5'd2, 1), 0, 0, '0, 1);
        idle(1); idle(1);

        check("scoreboard_drained", 128'(q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- Pipeline stage directly downstream of the ALU in the EX stage.
- Captures the ALU result and zero flag together with the instruction's memory and write-back control into the EX/MEM boundary.
- Resolves taken branches from the zero flag and exposes a forwarding tap.
- Uses a 2-entry skid buffer with valid/ready on both sides, so back-pressure from the MEM stage never combinationally reaches EX.

Parameters:
DATA_W, 32, datapath width (ALU result, store data, branch target)
REG_W, 5, register-index width

Ports:
clk_i  input  1  clock, all state updates on rising edge
rst_i  input  1  reset; asynchronous, active-low
flush_i  input  1  synchronous kill of all buffered beats
valid_i  input  1  EX beat present
ready_o  output  1  stage can accept a beat this cycle
result_i  input  DATA_W  ALU result
zero_i  input  1  ALU zero flag
store_data_i  input  DATA_W  rt value for stores
pc_branch_i  input  DATA_W  computed branch target
wb_reg_i  input  REG_W  destination register index
regwrite_i  input  1  write-back enable
memread_i  input  1  load
memwrite_i  input  1  store
branch_i  input  1  instruction is BEQ-type
valid_o  output  1  MEM beat present
ready_i  input  1  MEM stage accepts
result_o  output  DATA_W  buffered ALU result (memory address or write-back data)
store_data_o  output  DATA_W  buffered store data
wb_reg_o  output  REG_W  buffered destination
regwrite_o  output  1  buffered write-back enable
memread_o  output  1  buffered load
memwrite_o  output  1  buffered store
branch_taken_o  output  1  one-cycle pulse: accepted branch with zero_i=1
branch_target_o  output  DATA_W  target associated with the last taken branch
fwd_valid_o  output  1  valid_o & regwrite_o & (wb_reg_o != 0)
fwd_reg_o  output  REG_W  equals wb_reg_o
fwd_data_o  output  DATA_W  equals result_o

Behaviour:
- Reset (rst_i=0, asynchronous): both entry valid bits = 0; all payload registers = 0; branch_taken_o = 0; branch_target_o = 0.
  - Consequently valid_o = 0, fwd_valid_o = 0, ready_o = 1.
- Storage:
  - Output entry M drives all *_o payload outputs; valid_o = M.valid.
  - Skid entry S is hidden.
  - ready_o = !S.valid, taken directly from a flop with no combinational path from ready_i.
- Events per cycle:
  - accept = valid_i & ready_o.
  - pop = valid_o & ready_i.
- Update rules (flush_i=0):
  - M empty, or pop: M <= S if S.valid, else the input beat if accept, else M becomes empty. If S fed M, S <= the input beat when accept, else S becomes empty.
  - M full and no pop: on accept, input goes to S. No accept is possible while S is full.
- Ordering and throughput:
  - Beats leave in arrival order.
  - Sustained 1 beat/cycle when ready_i=1.
  - Latency from input to valid_o is 1 cycle.
  - The payload of a beat never changes while valid_o=1 and ready_i=0.
- Flush (flush_i=1): M.valid and S.valid <= 0 next edge. An input beat offered that cycle is discarded; the handshake still completes if ready_o=1. A pop in the same cycle is honoured by MEM. Flush has priority over every other update.
- Branch resolution:
  - branch_taken_o <= accept & branch_i & zero_i & !flush_i, so it is high for exactly one cycle after acceptance.
  - On that same edge, branch_target_o <= pc_branch_i; otherwise it holds.
  - branch_i=1 with zero_i=0 produces no pulse.
  - The branch beat still flows through the buffer with regwrite/memread/memwrite as given.
- Forwarding:
  - Purely combinational from M.
  - Writes to r0 never forward.
- Reset asserted mid-transfer: all buffered beats are lost, with no partial output. After release, ready_o=1 on the first cycle.
- No arithmetic is performed; all fields are passed through with their widths preserved.

Test Plan:
- Reset, then 4 back-to-back beats with results 0x1, 0x2, 0x3, 0x4 and ready_i=1 -> valid_o high cycles 1-4, result_o 1, 2, 3, 4 in order; ready_o stays 1.
- ready_i=0 while 3 beats are offered -> beats 1 and 2 accepted (M, S); ready_o=0 from the next cycle and beat 3 held. Then ready_i=1 -> outputs 1, 2, 3 in order, with no loss or duplication.
- Accept branch_i=1, zero_i=1, pc_branch_i=0x0040_0020 -> branch_taken_o=1 for exactly one cycle and branch_target_o=0x0040_0020. Repeat with zero_i=0 -> no pulse, target unchanged.
- Both entries full, then flush_i=1 together with valid_i=1 -> next cycle valid_o=0, ready_o=1, and the flushed beat never appears.
- Beat with regwrite_i=1, wb_reg_i=0 -> fwd_valid_o=0. Beat with wb_reg_i=8, result 0xDEAD_BEEF -> fwd_valid_o=1, fwd_reg_o=8, fwd_data_o=0xDEAD_BEEF.
- rst_i pulled low for half a cycle with M and S full -> outputs zero immediately (asynchronous); after release, ready_o=1 and valid_o=0.
